// File: rtl/registrador_acc.sv
// Accumulator register with add/subtract/load, multi-cycle logical shifts and zero/carry flags.
// Define REGISTRADOR_ACC_SATURATE_EN to clamp add overflow and subtract underflow.
module registrador_acc #(
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned SHAMT_W = 2
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic [3:0]         ty,
  input  logic [3:0]         tula,
  input  logic [WIDTH-1:0]   barramentodados,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic               valid,
  output logic               ready,
  output logic [WIDTH-1:0]   acumulador,
  output logic               carry,
  output logic               zero
);

  localparam logic [3:0] CmdClear  = 4'd0;
  localparam logic [3:0] CmdLoad   = 4'd1;
  localparam logic [3:0] CmdShiftR = 4'd3;
  localparam logic [3:0] CmdShiftL = 4'd4;

  localparam logic [3:0] AluAdd    = 4'd0;
  localparam logic [3:0] AluSub    = 4'd1;
  localparam logic [3:0] AluLoad   = 4'd2;

  typedef enum logic [0:0] {StIdle, StShift} state_e;

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     acc_q, acc_d;
  logic                 carry_q, carry_d;
  logic                 zero_q, zero_d;
  logic                 dir_q, dir_d;
  logic [SHAMT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH:0]       sum, diff;
  logic                 accept, is_shift;

  assign accept   = valid && (state_q == StIdle);
  assign is_shift = (ty == CmdShiftR) || (ty == CmdShiftL);
  assign sum      = {1'b0, acc_q} + {1'b0, barramentodados};
  // Top bit of the widened difference is the borrow.
  assign diff     = {1'b0, acc_q} - {1'b0, barramentodados};

  // State register and datapath registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      acc_q   <= '0;
      carry_q <= 1'b0;
      zero_q  <= 1'b1;
      dir_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      carry_q <= carry_d;
      zero_q  <= zero_d;
      dir_q   <= dir_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (accept && is_shift && (shamt != '0)) state_d = StShift;
      end
      StShift: begin
        if (cnt_q == SHAMT_W'(1)) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Datapath next values
  always_comb begin
    acc_d   = acc_q;
    carry_d = carry_q;
    dir_d   = dir_q;
    cnt_d   = cnt_q;
    if (state_q == StShift) begin
      if (dir_q) {carry_d, acc_d} = {acc_q, 1'b0};
      else       {acc_d, carry_d} = {1'b0, acc_q};
      cnt_d = cnt_q - SHAMT_W'(1);
    end else if (accept) begin
      case (ty)
        CmdClear: begin
          acc_d   = '0;
          carry_d = 1'b0;
        end
        CmdLoad: begin
          case (tula)
            AluAdd: begin
              {carry_d, acc_d} = sum;
`ifdef REGISTRADOR_ACC_SATURATE_EN
              if (sum[WIDTH]) acc_d = '1;
`endif
            end
            AluSub: begin
              acc_d   = diff[WIDTH-1:0];
              carry_d = diff[WIDTH];
`ifdef REGISTRADOR_ACC_SATURATE_EN
              if (diff[WIDTH]) acc_d = '0;
`endif
            end
            AluLoad: begin
              acc_d   = barramentodados;
              carry_d = 1'b0;
            end
            default: ;
          endcase
        end
        CmdShiftR, CmdShiftL: begin
          if (shamt == '0) begin
            carry_d = 1'b0;
          end else begin
            dir_d = (ty == CmdShiftL);
            cnt_d = shamt;
          end
        end
        default: ;
      endcase
    end
    zero_d = (acc_d == '0);
  end

  // Outputs
  always_comb begin
    ready      = (state_q == StIdle);
    acumulador = acc_q;
    carry      = carry_q;
    zero       = zero_q;
  end

endmodule

// File: tb/tb_registrador_acc.sv
// Directed self-checking bench for registrador_acc (WIDTH=4, SHAMT_W=2).
// Expected arithmetic results follow REGISTRADOR_ACC_SATURATE_EN when it is defined.
module tb_registrador_acc;

  logic       clock = 1'b0;
  logic       reset_n;
  logic [3:0] ty, tula, barramentodados;
  logic [1:0] shamt;
  logic       valid;
  logic       ready, carry, zero;
  logic [3:0] acumulador;

  int checks = 0;
  int passes = 0;

  registrador_acc #(.WIDTH(4), .SHAMT_W(2)) dut (
    .clock           (clock),
    .reset_n         (reset_n),
    .ty              (ty),
    .tula            (tula),
    .barramentodados (barramentodados),
    .shamt           (shamt),
    .valid           (valid),
    .ready           (ready),
    .acumulador      (acumulador),
    .carry           (carry),
    .zero            (zero)
  );

  always #5 clock = ~clock;

  // Present a command for one rising edge, then sample 1 time unit later.
  task automatic cmd(input logic [3:0] t, input logic [3:0] u, input logic [3:0] d,
                     input logic [1:0] s, input logic v);
    @(negedge clock);
    ty = t; tula = u; barramentodados = d; shamt = s; valid = v;
    @(posedge clock);
    #1;
    valid = 1'b0;
  endtask

  task automatic test_reset;
    reset_n = 1'b0; valid = 1'b0; ty = 4'd2; tula = 4'd0; barramentodados = 4'd0; shamt = 2'd0;
    #12;
    checks++; if (acumulador !== 4'h0) $display("FAIL reset_acc: got %h want 0", acumulador);
    else passes++;
    checks++; if ({carry, zero, ready} !== 3'b011)
      $display("FAIL reset_flags: carry/zero/ready got %b want 011", {carry, zero, ready});
    else passes++;
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  task automatic test_add;
    logic [3:0] exp_acc;
`ifdef REGISTRADOR_ACC_SATURATE_EN
    exp_acc = 4'hF;
`else
    exp_acc = 4'h1;
`endif
    cmd(4'd1, 4'd2, 4'h9, 2'd0, 1'b1);
    checks++; if ({acumulador, carry, zero} !== {4'h9, 2'b00})
      $display("FAIL load_direct: acc/c/z got %h/%b/%b want 9/0/0", acumulador, carry, zero);
    else passes++;
    cmd(4'd1, 4'd0, 4'h8, 2'd0, 1'b1);
    checks++; if ({acumulador, carry, zero} !== {exp_acc, 2'b10})
      $display("FAIL add_ovf: acc/c/z got %h/%b/%b want %h/1/0", acumulador, carry, zero, exp_acc);
    else passes++;
    cmd(4'd1, 4'd2, 4'h3, 2'd0, 1'b1);
    cmd(4'd1, 4'd0, 4'h4, 2'd0, 1'b1);
    checks++; if ({acumulador, carry} !== {4'h7, 1'b0})
      $display("FAIL add_plain: acc/c got %h/%b want 7/0", acumulador, carry);
    else passes++;
  endtask

  task automatic test_sub;
    logic [3:0] exp_acc;
    logic       exp_zero;
`ifdef REGISTRADOR_ACC_SATURATE_EN
    exp_acc = 4'h0; exp_zero = 1'b1;
`else
    exp_acc = 4'hE; exp_zero = 1'b0;
`endif
    cmd(4'd1, 4'd2, 4'h3, 2'd0, 1'b1);
    cmd(4'd1, 4'd1, 4'h5, 2'd0, 1'b1);
    checks++; if ({acumulador, carry, zero} !== {exp_acc, 1'b1, exp_zero})
      $display("FAIL sub_borrow: acc/c/z got %h/%b/%b want %h/1/%b",
               acumulador, carry, zero, exp_acc, exp_zero);
    else passes++;
    cmd(4'd1, 4'd2, 4'h7, 2'd0, 1'b1);
    cmd(4'd1, 4'd1, 4'h2, 2'd0, 1'b1);
    checks++; if ({acumulador, carry} !== {4'h5, 1'b0})
      $display("FAIL sub_plain: acc/c got %h/%b want 5/0", acumulador, carry);
    else passes++;
    cmd(4'd1, 4'd1, 4'h5, 2'd0, 1'b1);
    checks++; if ({acumulador, carry, zero} !== {4'h0, 2'b01})
      $display("FAIL sub_to_zero: acc/c/z got %h/%b/%b want 0/0/1", acumulador, carry, zero);
    else passes++;
  endtask

  task automatic test_shiftr;
    logic [3:0] exp_acc [3] = '{4'h5, 4'h2, 4'h1};
    logic       exp_c   [3] = '{1'b1, 1'b1, 1'b0};
    logic       exp_rdy [3] = '{1'b0, 1'b0, 1'b1};
    cmd(4'd1, 4'd2, 4'hB, 2'd0, 1'b1);
    cmd(4'd3, 4'd0, 4'h0, 2'd3, 1'b1);
    checks++; if ({acumulador, ready} !== {4'hB, 1'b0})
      $display("FAIL shiftr_enter: acc/ready got %h/%b want b/0", acumulador, ready);
    else passes++;
    // CLEAR pulses during the shift must be dropped.
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      ty = 4'd0; valid = 1'b1;
      @(posedge clock);
      #1;
      checks++; if ({acumulador, carry, ready} !== {exp_acc[i], exp_c[i], exp_rdy[i]})
        $display("FAIL shiftr_step%0d: acc/c/ready got %h/%b/%b want %h/%b/%b", i,
                 acumulador, carry, ready, exp_acc[i], exp_c[i], exp_rdy[i]);
      else passes++;
    end
    valid = 1'b0;
    @(posedge clock);
    #1;
    checks++; if ({acumulador, ready, zero} !== {4'h1, 2'b10})
      $display("FAIL shiftr_after: acc/ready/z got %h/%b/%b want 1/1/0", acumulador, ready, zero);
    else passes++;
  endtask

  task automatic test_shiftl;
    logic [3:0] exp_acc [3] = '{4'hA, 4'h4, 4'h8};
    logic       exp_c   [3] = '{1'b0, 1'b1, 1'b0};
    cmd(4'd1, 4'd2, 4'h5, 2'd0, 1'b1);
    cmd(4'd4, 4'd0, 4'h0, 2'd3, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(posedge clock);
      #1;
      checks++; if ({acumulador, carry} !== {exp_acc[i], exp_c[i]})
        $display("FAIL shiftl_step%0d: acc/c got %h/%b want %h/%b", i,
                 acumulador, carry, exp_acc[i], exp_c[i]);
      else passes++;
    end
    checks++; if (ready !== 1'b1) $display("FAIL shiftl_ready: got %b want 1", ready);
    else passes++;
  endtask

  task automatic test_shift_zero;
    cmd(4'd1, 4'd2, 4'h9, 2'd0, 1'b1);
    cmd(4'd4, 4'd0, 4'h0, 2'd0, 1'b1);
    checks++; if ({acumulador, carry, ready} !== {4'h9, 2'b01})
      $display("FAIL shiftl0: acc/c/ready got %h/%b/%b want 9/0/1", acumulador, carry, ready);
    else passes++;
    // Get carry=1 first so the shamt=0 clear of carry is observable.
    cmd(4'd1, 4'd2, 4'h3, 2'd0, 1'b1);
    cmd(4'd3, 4'd0, 4'h0, 2'd1, 1'b1);
    @(posedge clock);
    #1;
    checks++; if ({acumulador, carry} !== {4'h1, 1'b1})
      $display("FAIL shiftr1: acc/c got %h/%b want 1/1", acumulador, carry);
    else passes++;
    cmd(4'd3, 4'd0, 4'h0, 2'd0, 1'b1);
    checks++; if ({acumulador, carry, ready} !== {4'h1, 2'b01})
      $display("FAIL shiftr0: acc/c/ready got %h/%b/%b want 1/0/1", acumulador, carry, ready);
    else passes++;
  endtask

  task automatic test_reset_mid_shift;
    cmd(4'd1, 4'd2, 4'hC, 2'd0, 1'b1);
    cmd(4'd4, 4'd0, 4'h0, 2'd3, 1'b1);
    @(posedge clock);
    #1;
    checks++; if ({acumulador, carry, ready} !== {4'h8, 2'b10})
      $display("FAIL midshift_first: acc/c/ready got %h/%b/%b want 8/1/0", acumulador, carry, ready);
    else passes++;
    #2;
    reset_n = 1'b0;
    #1;
    checks++; if ({acumulador, carry, zero, ready} !== {4'h0, 3'b011})
      $display("FAIL midshift_reset: acc/c/z/ready got %h/%b/%b/%b want 0/0/1/1",
               acumulador, carry, zero, ready);
    else passes++;
    @(negedge clock);
    reset_n = 1'b1;
    cmd(4'd1, 4'd2, 4'h5, 2'd0, 1'b1);
    checks++; if ({acumulador, zero, ready} !== {4'h5, 2'b01})
      $display("FAIL post_reset_load: acc/z/ready got %h/%b/%b want 5/0/1", acumulador, zero, ready);
    else passes++;
  endtask

  task automatic test_clear_hold;
    cmd(4'd1, 4'd2, 4'h6, 2'd0, 1'b1);
    cmd(4'd0, 4'd0, 4'h0, 2'd0, 1'b0);
    checks++; if ({acumulador, zero} !== {4'h6, 1'b0})
      $display("FAIL clear_novalid: acc/z got %h/%b want 6/0", acumulador, zero);
    else passes++;
    cmd(4'd2, 4'd0, 4'hF, 2'd0, 1'b1);
    cmd(4'd7, 4'd0, 4'hF, 2'd0, 1'b1);
    cmd(4'd1, 4'd5, 4'hF, 2'd0, 1'b1);
    checks++; if ({acumulador, carry, zero} !== {4'h6, 2'b00})
      $display("FAIL hold_cmds: acc/c/z got %h/%b/%b want 6/0/0", acumulador, carry, zero);
    else passes++;
    cmd(4'd1, 4'd2, 4'hF, 2'd0, 1'b0);
    checks++; if (acumulador !== 4'h6)
      $display("FAIL load_novalid: acc got %h want 6", acumulador);
    else passes++;
    cmd(4'd0, 4'd0, 4'h0, 2'd0, 1'b1);
    checks++; if ({acumulador, carry, zero} !== {4'h0, 2'b01})
      $display("FAIL clear: acc/c/z got %h/%b/%b want 0/0/1", acumulador, carry, zero);
    else passes++;
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_shiftr();
    test_shiftl();
    test_shift_zero();
    test_reset_mid_shift();
    test_clear_hold();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/registrador_acc.md
REGISTRADOR_ACC -- requirements
Module: registrador_acc

Interface
REQ-001 Parameter WIDTH, default 4: accumulator and data-bus width in bits (min 2).
REQ-002 Parameter SHAMT_W, default 2: width of the shift-amount field.
REQ-003 Port clock  input  1: sole clock, all state updates on rising edge.
REQ-004 Port reset_n  input  1: asynchronous, active-low reset.
REQ-005 Port ty  input  4: command code (CLEAR=0, LOAD=1, HOLD=2, SHIFTR=3, SHIFTL=4, others = HOLD).
REQ-006 Port tula  input  4: LOAD sub-operation (0 = add, 1 = subtract, 2 = direct load, others = hold).
REQ-007 Port barramentodados  input  WIDTH: data-bus operand.
REQ-008 Port shamt  input  SHAMT_W: shift distance for SHIFTR/SHIFTL.
REQ-009 Port valid  input  1: command present on ty/tula/barramentodados/shamt.
REQ-010 Port ready  output  1: block can accept a command this cycle.
REQ-011 Port acumulador  output  WIDTH: registered accumulator value.
REQ-012 Port carry  output  1: registered carry/borrow/shifted-out bit.
REQ-013 Port zero  output  1: registered flag, 1 when acumulador is all zeros.

Function
REQ-014 A command SHALL be accepted only on a rising edge where valid=1 and ready=1; all other cycles leave acumulador, carry and zero unchanged.
REQ-015 FSM SHALL have states IDLE and SHIFT; ready=1 exactly in IDLE.
REQ-016 CLEAR accepted: acumulador<=0, carry<=0, zero<=1 next edge; stay IDLE.
REQ-017 LOAD/add: {carry,acumulador}<=acumulador+barramentodados (WIDTH+1-bit sum), one-cycle latency.
REQ-018 LOAD/subtract: acumulador<=acumulador-barramentodados modulo 2^WIDTH, carry<=1 if borrow (barramentodados>acumulador), else 0.
REQ-019 LOAD/direct: acumulador<=barramentodados, carry<=0.
REQ-020 HOLD, unknown ty, or LOAD with tula not 0/1/2: no state change except zero is re-evaluated (unchanged value).
REQ-021 SHIFTR/SHIFTL with shamt=0: completes in IDLE, acumulador unchanged, carry<=0, ready stays 1.
REQ-022 SHIFTR/SHIFTL with shamt=N>0: latch direction and N, enter SHIFT; each edge in SHIFT shifts one bit (logical, zero fill), carry<=bit shifted out, counter decrements; after the N-th shift return to IDLE, so ready is low for exactly N cycles.
REQ-023 zero SHALL always equal (acumulador==0) as of the same edge that updates acumulador.
REQ-024 valid asserted while in SHIFT SHALL be ignored (not queued); inputs may change freely during SHIFT.
REQ-025 Shift distance N >= WIDTH SHALL yield acumulador=0 with carry = last bit shifted out.

Reset
REQ-026 reset_n=0 SHALL immediately force acumulador=0, carry=0, zero=1, state IDLE, shift counter 0, ready=1.
REQ-027 Reset asserted mid-SHIFT SHALL abort the shift; after release the block is in IDLE accepting commands on the first rising edge.

Configuration
REQ-028 Macro REGISTRADOR_ACC_SATURATE_EN defined: add overflow SHALL clamp acumulador to all ones with carry=1; subtract underflow SHALL clamp to 0 with carry=1.
REQ-029 Macro undefined: add and subtract wrap modulo 2^WIDTH per REQ-017/REQ-018; shifts and other commands identical in both builds.

Verification (WIDTH=4, SHAMT_W=2)
REQ-030 Reset, then LOAD tula=2 data=0x9, then LOAD tula=0 data=0x8 -> acumulador=0x1, carry=1, zero=0 (unsaturated); 0xF, carry=1 with SATURATE_EN.
REQ-031 acumulador=0x3, LOAD tula=1 data=0x5 -> 0xE, carry=1 (unsaturated); 0x0, carry=1, zero=1 with SATURATE_EN.
REQ-032 acumulador=0xB, SHIFTR shamt=3 -> ready low 3 cycles, values 0x5,0x2,0x1, final carry=0; valid pulses during SHIFT ignored.
REQ-033 acumulador=0x9, SHIFTL shamt=0 -> acumulador 0x9, carry=0, ready never drops.
REQ-034 acumulador=0xC, SHIFTL shamt=3, reset_n low after first shift -> acumulador=0, zero=1, ready=1 asynchronously; next CLEAR/LOAD accepted on first edge after release.
REQ-035 Any value, CLEAR with valid=1 -> acumulador=0, carry=0, zero=1; same command with valid=0 -> no change.
